// File: rtl/fl_vadd_ctrl.sv
// Vector-add sequencer: PS AXI-lite register file plus a stream-to-DDR single-beat writer.
// Optional macro FL_VADD_IRQ_EN enables the registered completion interrupt (irq tied 0 otherwise).
module fl_vadd_ctrl #(
  parameter int AXI_VECTOR_WIDTH   = 32,
  parameter int AXI_PS_DATAWIDTH   = 32,
  parameter int AXI_PS_ADDR_WIDTH  = 5,
  parameter int AXI_DDR_DATAWIDTH  = 32,
  parameter int AXI_DDR_ADDR_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AXI_VECTOR_WIDTH-1:0]   sum_data,
  input  logic                          sum_valid,
  input  logic                          sum_tlast,
  output logic                          sum_ready,
  input  logic [AXI_PS_ADDR_WIDTH-1:0]  waddr,
  input  logic [AXI_PS_ADDR_WIDTH-1:0]  raddr,
  input  logic                          wavalid,
  input  logic                          wvalid,
  input  logic                          bready,
  input  logic                          arvalid,
  input  logic                          rready,
  input  logic [AXI_PS_DATAWIDTH-1:0]   wdata,
  output logic                          waready,
  output logic                          wready,
  output logic                          bvalid,
  output logic                          arready,
  output logic                          rvalid,
  output logic                          wresp,
  output logic [AXI_PS_DATAWIDTH-1:0]   rdata,
  output logic [AXI_DDR_ADDR_WIDTH-1:0] out_vector_waddr,
  output logic [AXI_DDR_DATAWIDTH-1:0]  out_vector_wdata,
  output logic                          out_vector_wavalid,
  output logic                          out_vector_wvalid,
  output logic                          out_vector_bready,
  input  logic                          out_vector_waready,
  input  logic                          out_vector_wready,
  input  logic                          out_vector_bvalid,
  input  logic                          out_vector_wresp,
  output logic                          irq
);
  localparam int AW = AXI_PS_ADDR_WIDTH;
  localparam int DW = AXI_PS_DATAWIDTH;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_D = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT_B = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  state_t                  state_r;
  logic [DW-1:0]           base_r, len_r, count_r, rdata_r;
  logic                    busy_r, done_r, err_r, irq_en_r, tlast_r;
  logic                    waready_r, bvalid_r, wresp_r, arready_r, rvalid_r;
  logic                    sum_ready_r, awvalid_r, dwvalid_r, dbready_r;
  logic [AXI_DDR_ADDR_WIDTH-1:0] daddr_r;
  logic [AXI_DDR_DATAWIDTH-1:0]  ddata_r;
  logic                    hs_w_s, bad_w_s, start_s, aw_ok_s, w_ok_s;
  logic [DW-1:0]           count_inc_s, rd_mux_s;

  assign hs_w_s      = waready_r & wavalid & wvalid;
  assign bad_w_s     = (waddr > AW'(3'd4));
  assign start_s     = hs_w_s & (waddr == AW'(3'd0)) & wdata[0] & (state_r == ST_IDLE);
  assign count_inc_s = count_r + DW'(1'b1);
  // An address/data channel counts as accepted if it handshakes now or already did.
  assign aw_ok_s     = ~awvalid_r | out_vector_waready;
  assign w_ok_s      = ~dwvalid_r | out_vector_wready;

  // Read-data multiplexer over the register map.
  always_comb begin
    rd_mux_s = {DW{1'b0}};
    case (raddr)
      AW'(3'd0): rd_mux_s[1]   = irq_en_r;
      AW'(3'd1): rd_mux_s[2:0] = {err_r, done_r, busy_r};
      AW'(3'd2): rd_mux_s      = base_r;
      AW'(3'd3): rd_mux_s      = len_r;
      AW'(3'd4): rd_mux_s      = count_r;
      default:   rd_mux_s      = {DW{1'b0}};
    endcase
  end

  // PS write channel and the writable configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waready_r <= 1'b0;
      bvalid_r  <= 1'b0;
      wresp_r   <= 1'b0;
      base_r    <= {DW{1'b0}};
      len_r     <= {DW{1'b0}};
      irq_en_r  <= 1'b0;
    end else begin
      waready_r <= wavalid & wvalid & ~bvalid_r & ~waready_r;
      if (hs_w_s) begin
        bvalid_r <= 1'b1;
        wresp_r  <= bad_w_s;
      end else if (bvalid_r & bready) begin
        bvalid_r <= 1'b0;
        wresp_r  <= 1'b0;
      end
      if (hs_w_s & ~bad_w_s) begin
        case (waddr)
          AW'(3'd0): irq_en_r <= wdata[1];
          AW'(3'd2): if (state_r == ST_IDLE) base_r <= wdata;
          AW'(3'd3): if (state_r == ST_IDLE) len_r <= wdata;
          default: ;
        endcase
      end
    end
  end

  // PS read channel; arready is the registered inverse of rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= {DW{1'b0}};
    end else if (rvalid_r & rready) begin
      rvalid_r  <= 1'b0;
      arready_r <= 1'b1;
    end else if (arready_r & arvalid) begin
      rvalid_r  <= 1'b1;
      arready_r <= 1'b0;
      rdata_r   <= rd_mux_s;
    end else begin
      arready_r <= ~rvalid_r;
    end
  end

  // Transfer sequencer: one stream element becomes one DDR write transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      count_r     <= {DW{1'b0}};
      tlast_r     <= 1'b0;
      sum_ready_r <= 1'b0;
      awvalid_r   <= 1'b0;
      dwvalid_r   <= 1'b0;
      dbready_r   <= 1'b0;
      daddr_r     <= {AXI_DDR_ADDR_WIDTH{1'b0}};
      ddata_r     <= {AXI_DDR_DATAWIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            count_r <= {DW{1'b0}};
            if (len_r == {DW{1'b0}}) begin
              state_r <= ST_FIN;
            end else begin
              state_r     <= ST_WAIT_D;
              sum_ready_r <= 1'b1;
            end
          end
        end
        ST_WAIT_D: begin
          if (sum_valid & sum_ready_r) begin
            sum_ready_r <= 1'b0;
            ddata_r     <= AXI_DDR_DATAWIDTH'(sum_data);
            tlast_r     <= sum_tlast;
            daddr_r     <= AXI_DDR_ADDR_WIDTH'(base_r + count_r);
            awvalid_r   <= 1'b1;
            dwvalid_r   <= 1'b1;
            state_r     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (awvalid_r & out_vector_waready) awvalid_r <= 1'b0;
          if (dwvalid_r & out_vector_wready) dwvalid_r <= 1'b0;
          if (aw_ok_s & w_ok_s) begin
            dbready_r <= 1'b1;
            state_r   <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (out_vector_bvalid) begin
            dbready_r <= 1'b0;
            count_r   <= count_inc_s;
            if (out_vector_wresp) begin
              err_r   <= 1'b1;
              state_r <= ST_FIN;
            end else if (count_inc_s == len_r) begin
              if (!tlast_r) err_r <= 1'b1;
              state_r <= ST_FIN;
            end else if (tlast_r) begin
              err_r   <= 1'b1;
              state_r <= ST_FIN;
            end else begin
              sum_ready_r <= 1'b1;
              state_r     <= ST_WAIT_D;
            end
          end
        end
        ST_FIN: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef FL_VADD_IRQ_EN
  logic irq_r;
  // Level interrupt follows sticky DONE gated by the enable bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_r <= 1'b0;
    else        irq_r <= done_r & irq_en_r;
  end
  assign irq = irq_r;
`else
  assign irq = 1'b0;
`endif

  assign sum_ready          = sum_ready_r;
  assign waready            = waready_r;
  assign wready             = waready_r;
  assign bvalid             = bvalid_r;
  assign wresp              = wresp_r;
  assign arready            = arready_r;
  assign rvalid             = rvalid_r;
  assign rdata              = rdata_r;
  assign out_vector_waddr   = daddr_r;
  assign out_vector_wdata   = ddata_r;
  assign out_vector_wavalid = awvalid_r;
  assign out_vector_wvalid  = dwvalid_r;
  assign out_vector_bready  = dbready_r;
endmodule

// File: tb/tb_fl_vadd_ctrl.sv
// Directed bench for fl_vadd_ctrl: PS register traffic, stream source and a DDR write responder.
module tb_fl_vadd_ctrl;
  logic        clk, rst_n;
  logic [31:0] sum_data;
  logic        sum_valid, sum_tlast, sum_ready;
  logic [4:0]  waddr, raddr;
  logic        wavalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata, rdata;
  logic        waready, wready, bvalid, arready, rvalid, wresp;
  logic [4:0]  out_vector_waddr;
  logic [31:0] out_vector_wdata;
  logic        out_vector_wavalid, out_vector_wvalid, out_vector_bready;
  logic        out_vector_waready, out_vector_wready, out_vector_bvalid, out_vector_wresp;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int err_b = -1;
  bit rnd_en = 1'b0;
  logic [4:0]  log_addr[$];
  logic [31:0] log_data[$];

`ifdef FL_VADD_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  fl_vadd_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .sum_data(sum_data), .sum_valid(sum_valid), .sum_tlast(sum_tlast), .sum_ready(sum_ready),
    .waddr(waddr), .raddr(raddr), .wavalid(wavalid), .wvalid(wvalid), .bready(bready),
    .arvalid(arvalid), .rready(rready), .wdata(wdata),
    .waready(waready), .wready(wready), .bvalid(bvalid), .arready(arready), .rvalid(rvalid),
    .wresp(wresp), .rdata(rdata),
    .out_vector_waddr(out_vector_waddr), .out_vector_wdata(out_vector_wdata),
    .out_vector_wavalid(out_vector_wavalid), .out_vector_wvalid(out_vector_wvalid),
    .out_vector_bready(out_vector_bready), .out_vector_waready(out_vector_waready),
    .out_vector_wready(out_vector_wready), .out_vector_bvalid(out_vector_bvalid),
    .out_vector_wresp(out_vector_wresp), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // DDR slave: handshakes seen at the previous negedge completed at the edge just past.
  initial begin
    logic p_awv, p_awr, p_wv, p_wr, p_bv, p_br;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    int outstanding;
    {p_awv, p_awr, p_wv, p_wr, p_bv, p_br} = 6'b0;
    p_addr = 5'd0; p_data = 32'd0;
    out_vector_waready = 1'b0; out_vector_wready = 1'b0;
    out_vector_bvalid = 1'b0; out_vector_wresp = 1'b0;
    forever begin
      @(negedge clk);
      if (p_awv && p_awr) begin aw_cnt++; log_addr.push_back(p_addr); end
      if (p_wv && p_wr) begin w_cnt++; log_data.push_back(p_data); end
      if (p_bv && p_br) b_cnt++;
      out_vector_waready = rnd_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      out_vector_wready  = rnd_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      outstanding = ((aw_cnt < w_cnt) ? aw_cnt : w_cnt) - b_cnt;
      if (!(out_vector_bvalid && !(p_bv && p_br)))
        out_vector_bvalid = (outstanding > 0) && (!rnd_en || ($urandom_range(0, 1) == 0));
      out_vector_wresp = (b_cnt == err_b);
      p_awv = out_vector_wavalid; p_awr = out_vector_waready;
      p_wv  = out_vector_wvalid;  p_wr  = out_vector_wready;
      p_bv  = out_vector_bvalid;  p_br  = out_vector_bready;
      p_addr = out_vector_waddr;  p_data = out_vector_wdata;
    end
  end

  task automatic ps_write(input logic [4:0] a, input logic [31:0] d, output logic resp);
    logic s;
    int t;
    waddr = a; wdata = d; wavalid = 1'b1; wvalid = 1'b1;
    t = 0;
    do begin s = waready; @(negedge clk); t++; end while (!s && t < 50);
    wavalid = 1'b0; wvalid = 1'b0;
    t = 0;
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    resp = wresp;
    if (!bvalid) begin check("ps_bvalid_timeout", 32'd0, 32'd1); resp = 1'bx; end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic ps_read(input logic [4:0] a, output logic [31:0] d);
    logic s;
    int t;
    raddr = a; arvalid = 1'b1;
    t = 0;
    do begin s = arready; @(negedge clk); t++; end while (!s && t < 50);
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 50) begin @(negedge clk); t++; end
    d = rvalid ? rdata : 32'hdead_beef;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    logic s;
    int t;
    sum_data = d; sum_tlast = last; sum_valid = 1'b1;
    t = 0;
    do begin s = sum_ready; @(negedge clk); t++; end while (!s && t < 200);
    check("sum_handshake", {31'd0, s}, 32'd1);
    sum_valid = 1'b0; sum_tlast = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    int t;
    t = 0;
    do begin ps_read(5'd1, st); t++; end while (st[0] && t < 100);
    check("wait_idle", {31'd0, st[0]}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic r;
    rst_n = 1'b0;
    sum_data = 32'd0; sum_valid = 1'b0; sum_tlast = 1'b0;
    waddr = 5'd0; raddr = 5'd0; wdata = 32'd0;
    wavalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_sum_ready", {31'd0, sum_ready}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      ps_read(i[4:0], rd);
      check($sformatf("rst_reg%0d", i), rd, 32'd0);
    end

    // Basic transfer
    ps_write(5'd2, 32'd4, r); check("base_wresp", {31'd0, r}, 32'd0);
    ps_write(5'd3, 32'd3, r);
    ps_write(5'd0, 32'd1, r);
    send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b1);
    wait_idle();
    check("t1_nwr", log_addr.size(), 32'd3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      check($sformatf("t1_addr%0d", i), {27'd0, log_addr[i]}, 32'd4 + i);
      check($sformatf("t1_data%0d", i), log_data[i], 32'd1 + i);
    end
    ps_read(5'd1, rd); check("t1_status", rd, 32'd2);
    ps_read(5'd4, rd); check("t1_count", rd, 32'd3);
    log_addr.delete(); log_data.delete();

    // Address wrap with random DDR back-pressure
    rnd_en = 1'b1;
    ps_write(5'd2, 32'd30, r);
    ps_write(5'd3, 32'd4, r);
    ps_write(5'd0, 32'd1, r);
    send(32'd10, 1'b0); send(32'd11, 1'b0); send(32'd12, 1'b0); send(32'd13, 1'b1);
    wait_idle();
    rnd_en = 1'b0;
    check("t2_nwr", log_addr.size(), 32'd4);
    check("t2_ndata", log_data.size(), 32'd4);
    if (log_addr.size() == 4 && log_data.size() == 4) begin
      check("t2_addr0", {27'd0, log_addr[0]}, 32'd30);
      check("t2_addr1", {27'd0, log_addr[1]}, 32'd31);
      check("t2_addr2", {27'd0, log_addr[2]}, 32'd0);
      check("t2_addr3", {27'd0, log_addr[3]}, 32'd1);
      check("t2_data3", log_data[3], 32'd13);
    end
    ps_read(5'd1, rd); check("t2_status", rd, 32'd2);
    ps_read(5'd4, rd); check("t2_count", rd, 32'd4);
    log_addr.delete(); log_data.delete();

    // Early tlast; configuration writes and START while busy are ignored
    ps_write(5'd2, 32'd8, r);
    ps_write(5'd3, 32'd5, r);
    ps_write(5'd0, 32'd1, r);
    fork
      begin
        repeat (20) @(negedge clk);
        send(32'd21, 1'b0); send(32'd22, 1'b1);
      end
      begin
        logic [31:0] st;
        logic rb;
        repeat (2) @(negedge clk);
        ps_read(5'd1, st); check("t3_busy", st, 32'd1);
        ps_write(5'd0, 32'd1, rb);
        ps_write(5'd2, 32'd99, rb); check("t3_busy_wresp", {31'd0, rb}, 32'd0);
        ps_write(5'd3, 32'd9, rb);
      end
    join
    wait_idle();
    check("t3_nwr", log_addr.size(), 32'd2);
    if (log_addr.size() == 2) check("t3_addr1", {27'd0, log_addr[1]}, 32'd9);
    ps_read(5'd1, rd); check("t3_status", rd, 32'd6);
    ps_read(5'd4, rd); check("t3_count", rd, 32'd2);
    ps_read(5'd2, rd); check("t3_base", rd, 32'd8);
    ps_read(5'd3, rd); check("t3_len", rd, 32'd5);
    log_addr.delete(); log_data.delete();

    // DDR error response on the first element aborts
    ps_write(5'd2, 32'd0, r);
    ps_write(5'd3, 32'd3, r);
    err_b = b_cnt;
    ps_write(5'd0, 32'd1, r);
    send(32'd31, 1'b0);
    wait_idle();
    err_b = -1;
    check("t4_nwr", log_addr.size(), 32'd1);
    ps_read(5'd1, rd); check("t4_status", rd, 32'd6);
    ps_read(5'd4, rd); check("t4_count", rd, 32'd1);
    log_addr.delete(); log_data.delete();

    // LEN=0 with IRQ_EN
    ps_write(5'd3, 32'd0, r);
    ps_write(5'd0, 32'd3, r);
    repeat (2) @(negedge clk);
    check("t5_irq", {31'd0, irq}, {31'd0, IRQ_EXP});
    ps_read(5'd1, rd); check("t5_status", rd, 32'd2);
    ps_read(5'd4, rd); check("t5_count", rd, 32'd0);
    ps_read(5'd0, rd); check("t5_ctrl", rd, 32'd2);
    check("t5_nwr", log_addr.size(), 32'd0);
    ps_write(5'd0, 32'd0, r);
    repeat (2) @(negedge clk);
    check("t5_irq_off", {31'd0, irq}, 32'd0);

    // Bad address
    ps_write(5'd7, 32'h1234, r); check("bad_wresp", {31'd0, r}, 32'd1);
    ps_read(5'd7, rd); check("bad_rdata", rd, 32'd0);
    ps_read(5'd2, rd); check("bad_no_alias", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
